exe_stage: RTL and testbench
============================

# exe_stage

Single-cycle execute stage of the MIPS core: accepts one decoded instruction per handshake, derives the 4-bit ALU operation code and operands, drives the core's ALU combinationally, and registers the result, branch decision and overflow trap into a one-entry output buffer. It sits between the decode stage (upstream, valid/ready) and the memory/writeback stage (downstream, valid/ready).

## Interface
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- clk  in  1  clock. Everything is sampled on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_op  in  6  opcode field.
- in_funct  in  6  funct field.
- in_shamt  in  5  shift-amount field.
- in_rs_val, in_rt_val  in  32  register operands.
- in_imm  in  16  immediate field.
- in_pc  in  32  instruction PC.
- in_dest  in  5  destination register, already selected by decode (rd or rt).
- alu_A, alu_B  out  32  ALU operands.
- alu_ALUop  out  4  ALU operation code.
- alu_Result  in  32  ALU result.
- alu_Zero, alu_Overflow, alu_CarryOut  in  1  ALU flags. CarryOut is unused.
- out_valid  out  1  result buffer holds an instruction.
- out_ready  in  1  downstream accepts.
- out_result  out  32  registered ALU result.
- out_dest  out  5  registered destination.
- out_wen  out  1  register write enable.
- out_br_taken  out  1  redirect fetch.
- out_br_target  out  32  redirect address.
- out_ovf_trap  out  1  signed-overflow exception.
- out_retired  out  32  count of instructions handed downstream.

## Operation
**ALU operation codes:** AND=0000, OR=0001, ADD=0010, NOR=0011, SL=0100, XOR=0101, SRL=0110, SRA=0111, SUB=1010, SLT=1011, SLTU=1111.

**Decode** is combinational from the in_* fields at all times, regardless of in_valid. Abbreviations: sext = sign-extend imm; zext = zero-extend imm.

- **R-type (op=000000)**, selected by funct:
  - ADD 100000 / ADDU 100001: ADD, A=rs, B=rt.
  - SUB 100010 / SUBU 100011: SUB, A=rs, B=rt.
  - AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011: the matching code, A=rs, B=rt.
  - SLL 000000 / SRL 000010 / SRA 000011: SL/SRL/SRA, A=rt, B={27'b0,shamt}.
  - SLLV 000100 / SRLV 000110 / SRAV 000111: the same codes, A=rt, B={27'b0,rs[4:0]}.
  - JR 001000: ADD, A=rs, B=0; branch taken, target=rs, no write.
- **I-type**, selected by op:
  - ADDI 001000 / ADDIU 001001: ADD, B=sext.
  - SLTI 001010: SLT, B=sext.
  - SLTIU 001011: SLTU, B=sext.
  - ANDI 001100 / ORI 001101 / XORI 001110: AND/OR/XOR, B=zext.
  - LUI 001111: SL, A=zext, B=16.
  - BEQ 000100: SUB, A=rs, B=rt; taken iff Zero.
  - BNE 000101: SUB, A=rs, B=rt; taken iff !Zero.
  - In all I-type cases A=rs unless stated otherwise.
- **Any other op or funct:** ADD with A=B=0, wen=0, not taken. The instruction still flows downstream.

**Branch target:** in_pc + 4 + (sext << 2), modulo 2^32. JR uses rs instead.

**Overflow trap:** only ADD, SUB and ADDI trap. When the trap fires, ovf_trap=1 and wen=0; the result is still registered.

**Write enable:** wen=0 for branches, JR, unknown instructions, trapped instructions, and in_dest==0.

**Handshake:**
- in_ready = !out_valid | out_ready (combinational).
- Accept when in_valid & in_ready. On accept, out_* load the values computed this cycle and out_valid←1.
- Otherwise, if out_ready, out_valid←0. While out_valid & !out_ready, all out_* hold.
- out_retired increments when out_valid & out_ready, and wraps from 0xFFFFFFFF to 0.

## Timing
- Latency 1 cycle: an accept at edge N makes the result visible after edge N.
- Throughput 1/cycle when out_ready stays high.
- Drain and refill in the same cycle: out_valid stays 1 with the new data, and the retired count still increments.
- Reset: out_valid=0, out_result=0, out_dest=0, out_wen=0, out_br_taken=0, out_br_target=0, out_ovf_trap=0, out_retired=0. in_ready is 1 in the cycle after reset. A pending result is discarded on rst regardless of out_ready.
- alu_* are purely combinational from the in_* fields. There is no ALU-path register.

## Test plan
- **Reset:** assert rst with in_valid=1 → all outputs 0 and nothing accepted; release → in_ready=1.
- **ADDU:** rs=0x7FFFFFFF, rt=1, dest=3 → alu_ALUop=0010; next cycle out_result=0x80000000, wen=1, trap=0. Same operands as ADD → trap=1, wen=0.
- **Shifts and LUI:**
  - SRA shamt=4, rt=0x80000000 → out_result=0xF8000000.
  - SRAV rs=0x24 (shift 4), same rt → same result.
  - LUI imm=0xABCD → 0xABCD0000.
- **Branch:** BEQ pc=0x100, rs=rt=5, imm=0xFFFF → taken, target=0x100, wen=0. BNE with the same operands → not taken.
- **Backpressure:** hold out_ready=0 over 3 issued ADDIUs → the first is held stable and in_ready=0; raise out_ready → one result per cycle, in order; out_retired ends at 3.
- **Edge cases:**
  - Unknown op 111111 → out_valid=1, wen=0.
  - dest=0 with ORI → wen=0.
  - Preload out_retired to 0xFFFFFFFF via 2^32-1 handshakes, or via a forced value in simulation, then one more handshake → 0.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: decodes one instruction into ALU controls, drives the core ALU
// combinationally and captures result, branch decision and overflow trap in a
// one-entry output buffer with valid/ready handshakes on both sides.
module exe_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            in_op,
    input  logic [5:0]            in_funct,
    input  logic [4:0]            in_shamt,
    input  logic [DATA_WIDTH-1:0] in_rs_val,
    input  logic [DATA_WIDTH-1:0] in_rt_val,
    input  logic [15:0]           in_imm,
    input  logic [31:0]           in_pc,
    input  logic [4:0]            in_dest,

    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [3:0]            alu_ALUop,
    input  logic [DATA_WIDTH-1:0] alu_Result,
    input  logic                  alu_Zero,
    input  logic                  alu_Overflow,
    input  logic                  alu_CarryOut,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [4:0]            out_dest,
    output logic                  out_wen,
    output logic                  out_br_taken,
    output logic [31:0]           out_br_target,
    output logic                  out_ovf_trap,
    output logic [31:0]           out_retired
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_NOR  = 4'b0011;
    localparam logic [3:0] ALU_SL   = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    // Carry out of the ALU has no consumer in this stage.
    logic unused_carry;
    assign unused_carry = alu_CarryOut;

    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    assign imm_sext = {{16{in_imm[15]}}, in_imm};
    assign imm_zext = {16'h0000, in_imm};

    logic [3:0]            dec_op;
    logic [DATA_WIDTH-1:0] dec_a;
    logic [DATA_WIDTH-1:0] dec_b;
    logic                  dec_writes;
    logic                  dec_jr;
    logic                  dec_beq;
    logic                  dec_bne;
    logic                  dec_can_trap;

    // Instruction decode; unknown encodings fall through to a harmless 0+0.
    always_comb begin
        dec_op       = ALU_ADD;
        dec_a        = '0;
        dec_b        = '0;
        dec_writes   = 1'b0;
        dec_jr       = 1'b0;
        dec_beq      = 1'b0;
        dec_bne      = 1'b0;
        dec_can_trap = 1'b0;
        case (in_op)
            6'b000000: begin
                case (in_funct)
                    6'b100000: begin dec_op = ALU_ADD; dec_a = in_rs_val; dec_b = in_rt_val; dec_writes = 1'b1; dec_can_trap = 1'b1; end
                    6'b100001: begin dec_op = ALU_ADD; dec_a = in_rs_val; dec_b = in_rt_val; dec_writes = 1'b1; end
                    6'b100010: begin dec_op = ALU_SUB; dec_a = in_rs_val; dec_b = in_rt_val; dec_writes = 1'b1; dec_can_trap = 1'b1; end
                    6'b100011: begin dec_op = ALU_SUB; dec_a = in_rs_val; dec_b = in_rt_val; dec_writes = 1'b1; end
                    6'b100100: begin dec_op = ALU_AND; dec_a = in_rs_val; dec_b = in_rt_val; dec_writes = 1'b1; end
                    6'b100101: begin dec_op = ALU_OR;  dec_a = in_rs_val; dec_b = in_rt_val; dec_writes = 1'b1; end
                    6'b100110: begin dec_op = ALU_XOR; dec_a = in_rs_val; dec_b = in_rt_val; dec_writes = 1'b1; end
                    6'b100111: begin dec_op = ALU_NOR; dec_a = in_rs_val; dec_b = in_rt_val; dec_writes = 1'b1; end
                    6'b101010: begin dec_op = ALU_SLT; dec_a = in_rs_val; dec_b = in_rt_val; dec_writes = 1'b1; end
                    6'b101011: begin dec_op = ALU_SLTU; dec_a = in_rs_val; dec_b = in_rt_val; dec_writes = 1'b1; end
                    6'b000000: begin dec_op = ALU_SL;  dec_a = in_rt_val; dec_b = {27'b0, in_shamt}; dec_writes = 1'b1; end
                    6'b000010: begin dec_op = ALU_SRL; dec_a = in_rt_val; dec_b = {27'b0, in_shamt}; dec_writes = 1'b1; end
                    6'b000011: begin dec_op = ALU_SRA; dec_a = in_rt_val; dec_b = {27'b0, in_shamt}; dec_writes = 1'b1; end
                    6'b000100: begin dec_op = ALU_SL;  dec_a = in_rt_val; dec_b = {27'b0, in_rs_val[4:0]}; dec_writes = 1'b1; end
                    6'b000110: begin dec_op = ALU_SRL; dec_a = in_rt_val; dec_b = {27'b0, in_rs_val[4:0]}; dec_writes = 1'b1; end
                    6'b000111: begin dec_op = ALU_SRA; dec_a = in_rt_val; dec_b = {27'b0, in_rs_val[4:0]}; dec_writes = 1'b1; end
                    6'b001000: begin dec_op = ALU_ADD; dec_a = in_rs_val; dec_b = '0; dec_jr = 1'b1; end
                    default: ;
                endcase
            end
            6'b001000: begin dec_op = ALU_ADD;  dec_a = in_rs_val; dec_b = imm_sext; dec_writes = 1'b1; dec_can_trap = 1'b1; end
            6'b001001: begin dec_op = ALU_ADD;  dec_a = in_rs_val; dec_b = imm_sext; dec_writes = 1'b1; end
            6'b001010: begin dec_op = ALU_SLT;  dec_a = in_rs_val; dec_b = imm_sext; dec_writes = 1'b1; end
            6'b001011: begin dec_op = ALU_SLTU; dec_a = in_rs_val; dec_b = imm_sext; dec_writes = 1'b1; end
            6'b001100: begin dec_op = ALU_AND;  dec_a = in_rs_val; dec_b = imm_zext; dec_writes = 1'b1; end
            6'b001101: begin dec_op = ALU_OR;   dec_a = in_rs_val; dec_b = imm_zext; dec_writes = 1'b1; end
            6'b001110: begin dec_op = ALU_XOR;  dec_a = in_rs_val; dec_b = imm_zext; dec_writes = 1'b1; end
            6'b001111: begin dec_op = ALU_SL;   dec_a = imm_zext;  dec_b = 32'd16;   dec_writes = 1'b1; end
            6'b000100: begin dec_op = ALU_SUB;  dec_a = in_rs_val; dec_b = in_rt_val; dec_beq = 1'b1; end
            6'b000101: begin dec_op = ALU_SUB;  dec_a = in_rs_val; dec_b = in_rt_val; dec_bne = 1'b1; end
            default: ;
        endcase
    end

    assign alu_A     = dec_a;
    assign alu_B     = dec_b;
    assign alu_ALUop = dec_op;

    logic        exe_trap;
    logic        exe_taken;
    logic        exe_wen;
    logic [31:0] exe_target;

    assign exe_trap   = dec_can_trap & alu_Overflow;
    assign exe_taken  = dec_jr | (dec_beq & alu_Zero) | (dec_bne & ~alu_Zero);
    assign exe_wen    = dec_writes & ~exe_trap & (in_dest != 5'd0);
    assign exe_target = dec_jr ? in_rs_val : (in_pc + 32'd4 + {imm_sext[29:0], 2'b00});

    logic                  valid_q,  valid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [4:0]            dest_q,   dest_d;
    logic                  wen_q,    wen_d;
    logic                  taken_q,  taken_d;
    logic [31:0]           target_q, target_d;
    logic                  trap_q,   trap_d;
    logic [31:0]           retired_q, retired_d;

    assign in_ready = ~valid_q | out_ready;

    // Buffer next state: load on accept, empty on drain, otherwise hold.
    always_comb begin
        valid_d   = valid_q;
        result_d  = result_q;
        dest_d    = dest_q;
        wen_d     = wen_q;
        taken_d   = taken_q;
        target_d  = target_q;
        trap_d    = trap_q;
        retired_d = retired_q;
        if (valid_q && out_ready) begin
            retired_d = retired_q + 32'd1;
        end
        if (in_valid && in_ready) begin
            valid_d  = 1'b1;
            result_d = alu_Result;
            dest_d   = in_dest;
            wen_d    = exe_wen;
            taken_d  = exe_taken;
            target_d = exe_target;
            trap_d   = exe_trap;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output buffer and retire counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            result_q  <= '0;
            dest_q    <= '0;
            wen_q     <= 1'b0;
            taken_q   <= 1'b0;
            target_q  <= '0;
            trap_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            valid_q   <= valid_d;
            result_q  <= result_d;
            dest_q    <= dest_d;
            wen_q     <= wen_d;
            taken_q   <= taken_d;
            target_q  <= target_d;
            trap_q    <= trap_d;
            retired_q <= retired_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_result    = result_q;
    assign out_dest      = dest_q;
    assign out_wen       = wen_q;
    assign out_br_taken  = taken_q;
    assign out_br_target = target_q;
    assign out_ovf_trap  = trap_q;
    assign out_retired   = retired_q;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: a reference model predicts each accepted
// instruction's result; a monitor compares whatever the stage presents.
module tb_exe_stage;

    typedef struct {
        logic [3:0]  aluop;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        wen;
        logic        taken;
        logic [31:0] target;
        logic        trap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [5:0]  in_op, in_funct;
    logic [4:0]  in_shamt, in_dest;
    logic [31:0] in_rs_val, in_rt_val, in_pc;
    logic [15:0] in_imm;
    logic [31:0] alu_A, alu_B, alu_Result;
    logic [3:0]  alu_ALUop;
    logic        alu_Zero, alu_Overflow, alu_CarryOut;
    logic        out_valid, out_ready, out_wen, out_br_taken, out_ovf_trap;
    logic [31:0] out_result, out_br_target, out_retired;
    logic [4:0]  out_dest;

    int          checks = 0;
    int          errors = 0;
    exp_t        sbq[$];
    logic [31:0] ret_model = '0;
    bit          mon_en = 1'b0;
    bit          rand_rdy = 1'b0;

    always #5 clk = ~clk;

    exe_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_funct(in_funct), .in_shamt(in_shamt),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
        .in_pc(in_pc), .in_dest(in_dest),
        .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop),
        .alu_Result(alu_Result), .alu_Zero(alu_Zero),
        .alu_Overflow(alu_Overflow), .alu_CarryOut(alu_CarryOut),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dest(out_dest), .out_wen(out_wen),
        .out_br_taken(out_br_taken), .out_br_target(out_br_target),
        .out_ovf_trap(out_ovf_trap), .out_retired(out_retired)
    );

    // Behavioural core ALU the stage drives.
    always_comb begin
        alu_Result   = '0;
        alu_Overflow = 1'b0;
        alu_CarryOut = 1'b0;
        case (alu_ALUop)
            4'b0000: alu_Result = alu_A & alu_B;
            4'b0001: alu_Result = alu_A | alu_B;
            4'b0010: begin
                alu_Result   = alu_A + alu_B;
                alu_Overflow = (alu_A[31] == alu_B[31]) && (alu_Result[31] != alu_A[31]);
            end
            4'b0011: alu_Result = ~(alu_A | alu_B);
            4'b0100: alu_Result = alu_A << alu_B[4:0];
            4'b0101: alu_Result = alu_A ^ alu_B;
            4'b0110: alu_Result = alu_A >> alu_B[4:0];
            4'b0111: alu_Result = $signed(alu_A) >>> alu_B[4:0];
            4'b1010: begin
                alu_Result   = alu_A - alu_B;
                alu_Overflow = (alu_A[31] != alu_B[31]) && (alu_Result[31] != alu_A[31]);
            end
            4'b1011: alu_Result = ($signed(alu_A) < $signed(alu_B)) ? 32'd1 : 32'd0;
            4'b1111: alu_Result = (alu_A < alu_B) ? 32'd1 : 32'd0;
            default: alu_Result = '0;
        endcase
        alu_Zero = (alu_Result == 32'd0);
    end

    function automatic logic ovf(input logic [31:0] a, input logic [31:0] b, input bit sub);
        longint s;
        longint lim;
        lim = 64'sd2147483647;
        s = sub ? (longint'($signed(a)) - longint'($signed(b)))
                : (longint'($signed(a)) + longint'($signed(b)));
        return (s > lim) || (s < -lim - 1);
    endfunction

    function automatic exp_t model(input logic [5:0] op, input logic [5:0] funct,
                                   input logic [4:0] shamt, input logic [31:0] rs,
                                   input logic [31:0] rt, input logic [15:0] imm,
                                   input logic [31:0] pc, input logic [4:0] dest);
        exp_t        e;
        logic [31:0] sx, zx;
        bit          wr;
        sx = {{16{imm[15]}}, imm};
        zx = {16'h0, imm};
        e.aluop  = 4'b0010;
        e.result = 32'd0;
        e.dest   = dest;
        e.taken  = 1'b0;
        e.trap   = 1'b0;
        e.target = pc + 32'd4 + sx * 32'd4;
        wr = 1'b0;
        if (op == 6'h00) begin
            wr = 1'b1;
            case (funct)
                6'h20: begin e.aluop = 4'b0010; e.result = rs + rt; e.trap = ovf(rs, rt, 1'b0); end
                6'h21: begin e.aluop = 4'b0010; e.result = rs + rt; end
                6'h22: begin e.aluop = 4'b1010; e.result = rs - rt; e.trap = ovf(rs, rt, 1'b1); end
                6'h23: begin e.aluop = 4'b1010; e.result = rs - rt; end
                6'h24: begin e.aluop = 4'b0000; e.result = rs & rt; end
                6'h25: begin e.aluop = 4'b0001; e.result = rs | rt; end
                6'h26: begin e.aluop = 4'b0101; e.result = rs ^ rt; end
                6'h27: begin e.aluop = 4'b0011; e.result = ~(rs | rt); end
                6'h2a: begin e.aluop = 4'b1011; e.result = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
                6'h2b: begin e.aluop = 4'b1111; e.result = (rs < rt) ? 32'd1 : 32'd0; end
                6'h00: begin e.aluop = 4'b0100; e.result = rt << shamt; end
                6'h02: begin e.aluop = 4'b0110; e.result = rt >> shamt; end
                6'h03: begin e.aluop = 4'b0111; e.result = $signed(rt) >>> shamt; end
                6'h04: begin e.aluop = 4'b0100; e.result = rt << rs[4:0]; end
                6'h06: begin e.aluop = 4'b0110; e.result = rt >> rs[4:0]; end
                6'h07: begin e.aluop = 4'b0111; e.result = $signed(rt) >>> rs[4:0]; end
                6'h08: begin e.result = rs; e.taken = 1'b1; e.target = rs; wr = 1'b0; end
                default: wr = 1'b0;
            endcase
        end else begin
            wr = 1'b1;
            case (op)
                6'h08: begin e.result = rs + sx; e.trap = ovf(rs, sx, 1'b0); end
                6'h09: begin e.result = rs + sx; end
                6'h0a: begin e.aluop = 4'b1011; e.result = ($signed(rs) < $signed(sx)) ? 32'd1 : 32'd0; end
                6'h0b: begin e.aluop = 4'b1111; e.result = (rs < sx) ? 32'd1 : 32'd0; end
                6'h0c: begin e.aluop = 4'b0000; e.result = rs & zx; end
                6'h0d: begin e.aluop = 4'b0001; e.result = rs | zx; end
                6'h0e: begin e.aluop = 4'b0101; e.result = rs ^ zx; end
                6'h0f: begin e.aluop = 4'b0100; e.result = zx * 32'd65536; end
                6'h04: begin e.aluop = 4'b1010; e.result = rs - rt; e.taken = (rs == rt); wr = 1'b0; end
                6'h05: begin e.aluop = 4'b1010; e.result = rs - rt; e.taken = (rs != rt); wr = 1'b0; end
                default: wr = 1'b0;
            endcase
        end
        e.wen = wr && !e.trap && (dest != 5'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present one instruction and wait (bounded) until the stage takes it.
    task automatic issue(input logic [5:0] op, input logic [5:0] funct, input logic [4:0] shamt,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                         input logic [31:0] pc, input logic [4:0] dest);
        exp_t e;
        bit   done;
        done = 1'b0;
        e = model(op, funct, shamt, rs, rt, imm, pc, dest);
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = op;
        in_funct  = funct;
        in_shamt  = shamt;
        in_rs_val = rs;
        in_rt_val = rt;
        in_imm    = imm;
        in_pc     = pc;
        in_dest   = dest;
        #1;
        chk("alu_op", {28'h0, alu_ALUop}, {28'h0, e.aluop});
        for (int t = 0; t < 40 && !done; t++) begin
            if (t > 0) begin
                @(negedge clk);
                #1;
            end
            if (in_ready) begin
                sbq.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=stalled required=accepted");
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        chk("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    // Monitor: compare presented output with scoreboard head, track retire count.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && !rst) begin
                chk("in_ready", {31'h0, in_ready}, {31'h0, (!out_valid || out_ready)});
                if (out_valid) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output actual=valid required=idle");
                    end else begin
                        e = sbq[0];
                        chk("result", out_result, e.result);
                        chk("dest", {27'h0, out_dest}, {27'h0, e.dest});
                        chk("wen", {31'h0, out_wen}, {31'h0, e.wen});
                        chk("br_taken", {31'h0, out_br_taken}, {31'h0, e.taken});
                        chk("br_target", out_br_target, e.target);
                        chk("ovf_trap", {31'h0, out_ovf_trap}, {31'h0, e.trap});
                        if (out_ready) void'(sbq.pop_front());
                    end
                end
                chk("retired", out_retired, ret_model);
                if (out_valid && out_ready) ret_model = ret_model + 32'd1;
            end
        end
    end

    // Random downstream backpressure.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'(5);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [5:0]  r_funct[18];
        logic [5:0]  i_op[12];
        logic [5:0]  op, fn;
        logic [31:0] rs, rt, rw;

        r_funct = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                    6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h3f};
        i_op    = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
                    6'h04, 6'h05, 6'h3f, 6'h02};

        // Reset with a valid instruction pending at the input.
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_op = 6'h00; in_funct = 6'h21; in_shamt = 5'd0;
        in_rs_val = 32'h7FFF_FFFF; in_rt_val = 32'd1; in_imm = 16'h0;
        in_pc = 32'h0; in_dest = 5'd3;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_dest", {27'h0, out_dest}, 32'd0);
        chk("rst_wen", {31'h0, out_wen}, 32'd0);
        chk("rst_taken", {31'h0, out_br_taken}, 32'd0);
        chk("rst_target", out_br_target, 32'd0);
        chk("rst_trap", {31'h0, out_ovf_trap}, 32'd0);
        chk("rst_retired", out_retired, 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'h0, in_ready}, 32'd1);
        @(negedge clk);
        #1;
        chk("post_rst_empty", {31'h0, out_valid}, 32'd0);
        mon_en = 1'b1;

        // Directed instructions.
        issue(6'h00, 6'h21, 5'd0, 32'h7FFF_FFFF, 32'd1, 16'h0, 32'h0, 5'd3);        // ADDU
        issue(6'h00, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'd1, 16'h0, 32'h0, 5'd3);        // ADD trap
        issue(6'h00, 6'h03, 5'd4, 32'h0, 32'h8000_0000, 16'h0, 32'h0, 5'd5);        // SRA
        issue(6'h00, 6'h07, 5'd0, 32'h24, 32'h8000_0000, 16'h0, 32'h0, 5'd6);       // SRAV
        issue(6'h0f, 6'h00, 5'd0, 32'h1234, 32'h0, 16'hABCD, 32'h0, 5'd7);          // LUI
        issue(6'h04, 6'h00, 5'd0, 32'd5, 32'd5, 16'hFFFF, 32'h100, 5'd8);           // BEQ
        issue(6'h05, 6'h00, 5'd0, 32'd5, 32'd5, 16'hFFFF, 32'h100, 5'd8);           // BNE
        issue(6'h3f, 6'h00, 5'd0, 32'd9, 32'd9, 16'h1, 32'h40, 5'd9);               // unknown
        issue(6'h0d, 6'h00, 5'd0, 32'hF0, 32'h0, 16'h0F0F, 32'h0, 5'd0);            // ORI to r0
        issue(6'h00, 6'h08, 5'd0, 32'h0000_2000, 32'h0, 16'h0, 32'h80, 5'd31);      // JR
        idle();
        drain();

        // A pending result is dropped by reset even while downstream stalls.
        out_ready = 1'b0;
        issue(6'h09, 6'h00, 5'd0, 32'd10, 32'd0, 16'd1, 32'h0, 5'd4);
        idle();
        @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        #1;
        chk("rst_discard", {31'h0, out_valid}, 32'd0);
        ret_model = 32'd0;
        rst = 1'b0;

        // Backpressure over three ADDIUs.
        issue(6'h09, 6'h00, 5'd0, 32'd100, 32'd0, 16'd1, 32'h0, 5'd1);
        fork
            issue(6'h09, 6'h00, 5'd0, 32'd200, 32'd0, 16'd2, 32'h0, 5'd2);
            begin
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    chk("bp_in_ready", {31'h0, in_ready}, 32'd0);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        issue(6'h09, 6'h00, 5'd0, 32'd300, 32'd0, 16'hFFFF, 32'h0, 5'd3);
        idle();
        drain();
        chk("bp_retired", out_retired, 32'd3);

        // Retire counter wraps.
        @(negedge clk);
        force dut.retired_q = 32'hFFFF_FFFF;
        ret_model = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        issue(6'h0d, 6'h00, 5'd0, 32'h1, 32'h0, 16'h2, 32'h0, 5'd10);
        idle();
        drain();
        chk("retired_wrap", out_retired, 32'd0);

        // Randomized traffic with random downstream stalls.
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            rs = rnd_val();
            rt = ($urandom_range(0, 3) == 0) ? rs : rnd_val();
            rw = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                op = 6'h00;
                fn = r_funct[$urandom_range(0, 17)];
            end else begin
                op = i_op[$urandom_range(0, 11)];
                fn = rw[5:0];
            end
            issue(op, fn, rw[10:6], rs, rt, rw[31:16], {rw[15:2], 2'b00} ^ 32'h0040_0000, rw[15:11]);
        end
        idle();
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
